// File: rtl/shrimp_reg_file.sv
// ----------------------------------------------------------------------------
// shrimp_reg_file
//
// General-purpose register file for the shrimp 8-bit CPU. It holds NUM_REGS
// registers of DATA_WIDTH bits each. Two independent read ports feed the ALU
// source operands, and one write port accepts the writeback result.
//
// Reads are purely combinational from the address and the stored state. There
// is no write-to-read bypass: a read of a register that is being written shows
// the old contents until the capturing clock edge.
//
// r0 is an ordinary writable register; it is not hardwired to zero.
//
// Ports:
//   clock         in   rising-edge write clock
//   reset_n       in   asynchronous active-low reset, clears every register
//   reg_r_a_addr  in   read port A address
//   reg_r_b_addr  in   read port B address
//   reg_w_addr    in   write address
//   reg_w_val     in   write data
//   reg_w_enable  in   commit reg_w_val to reg_w_addr on the rising edge
//   reg_r_a_val   out  contents of register reg_r_a_addr
//   reg_r_b_val   out  contents of register reg_r_b_addr
// ----------------------------------------------------------------------------
module shrimp_reg_file #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REGS   = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] reg_r_a_addr,
    input  logic [ADDR_WIDTH-1:0] reg_r_b_addr,
    input  logic [ADDR_WIDTH-1:0] reg_w_addr,
    input  logic [DATA_WIDTH-1:0] reg_w_val,
    input  logic                  reg_w_enable,
    output logic [DATA_WIDTH-1:0] reg_r_a_val,
    output logic [DATA_WIDTH-1:0] reg_r_b_val
);

    // Register storage, r0..r(NUM_REGS-1).
    logic [DATA_WIDTH-1:0] regs_r [NUM_REGS];

    // Storage update: async clear, otherwise a single-register write when enabled.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (reg_w_enable) begin
            regs_r[reg_w_addr] <= reg_w_val;
        end
    end

    // Combinational read ports. The outputs reflect stored state only, so a
    // write becomes visible just after its edge and never before it.
    always_comb begin
        reg_r_a_val = regs_r[reg_r_a_addr];
        reg_r_b_val = regs_r[reg_r_b_addr];
    end

endmodule

// File: tb/tb_shrimp_reg_file.sv
// ----------------------------------------------------------------------------
// tb_shrimp_reg_file
//
// Directed self-checking bench for shrimp_reg_file. Expected values are
// hand-computed constants. Outputs are sampled 1 time unit after a rising edge,
// or at points between edges.
// ----------------------------------------------------------------------------
module tb_shrimp_reg_file;

    logic       clock;
    logic       reset_n;
    logic [3:0] reg_r_a_addr;
    logic [3:0] reg_r_b_addr;
    logic [3:0] reg_w_addr;
    logic [7:0] reg_w_val;
    logic       reg_w_enable;
    logic [7:0] reg_r_a_val;
    logic [7:0] reg_r_b_val;

    int n_compared   = 0;
    int n_mismatched = 0;

    shrimp_reg_file #(
        .DATA_WIDTH (8),
        .NUM_REGS   (16),
        .ADDR_WIDTH (4)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .reg_r_a_addr (reg_r_a_addr),
        .reg_r_b_addr (reg_r_b_addr),
        .reg_w_addr   (reg_w_addr),
        .reg_w_val    (reg_w_val),
        .reg_w_enable (reg_w_enable),
        .reg_r_a_val  (reg_r_a_val),
        .reg_r_b_val  (reg_r_b_val)
    );

    // Free-running clock, period 10 time units.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Count one comparison and report it if the observed value differs from the expected value.
    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    // Wait for the next rising edge, then step past it before sampling.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Directed test sequence.
    initial begin
        reset_n      = 1'b0;
        reg_r_a_addr = 4'd0;
        reg_r_b_addr = 4'd0;
        reg_w_addr   = 4'd0;
        reg_w_val    = 8'd0;
        reg_w_enable = 1'b0;

        // Reset state: both ports read r0 as zero.
        #3;
        check_eq("rst_a0", reg_r_a_val, 8'h00);
        check_eq("rst_b0", reg_r_b_val, 8'h00);
        #9;
        reset_n = 1'b1;   // release between edges (t=12)

        // Sweep every address after reset.
        for (int i = 0; i < 16; i++) begin
            reg_r_a_addr = 4'(i);
            reg_r_b_addr = 4'(15 - i);
            #1;
            check_eq($sformatf("rst_sweep_a%0d", i), reg_r_a_val, 8'h00);
            check_eq($sformatf("rst_sweep_b%0d", i), reg_r_b_val, 8'h00);
        end

        // Basic write: r0 <= 120. The old value is visible before the edge and the new value after it.
        tick();
        reg_w_addr   = 4'd0;
        reg_w_val    = 8'd120;
        reg_w_enable = 1'b1;
        reg_r_a_addr = 4'd0;
        reg_r_b_addr = 4'd1;
        #1;
        check_eq("wr_pre_a", reg_r_a_val, 8'h00);
        tick();
        reg_w_enable = 1'b0;
        check_eq("wr_post_a", reg_r_a_val, 8'd120);
        check_eq("wr_post_b", reg_r_b_val, 8'h00);

        // Write disable: r3 must not take 0xAA.
        reg_w_addr   = 4'd3;
        reg_w_val    = 8'hAA;
        reg_w_enable = 1'b0;
        reg_r_a_addr = 4'd3;
        tick();
        check_eq("wr_dis_r3", reg_r_a_val, 8'h00);

        // Full sweep: r[i] = 0x10 + i.
        for (int i = 0; i < 16; i++) begin
            reg_w_addr   = 4'(i);
            reg_w_val    = 8'(8'h10 + i);
            reg_w_enable = 1'b1;
            tick();
        end
        reg_w_enable = 1'b0;
        for (int i = 0; i < 16; i++) begin
            reg_r_a_addr = 4'(i);
            reg_r_b_addr = 4'(15 - i);
            #1;
            check_eq($sformatf("sweep_a%0d", i), reg_r_a_val, 8'(8'h10 + i));
            check_eq($sformatf("sweep_b%0d", i), reg_r_b_val, 8'(8'h1F - i));
        end

        // Async reset mid-cycle, with a write pending while reset is low.
        tick();
        reg_r_a_addr = 4'd4;
        reg_r_b_addr = 4'd11;
        #1;
        check_eq("pre_arst_a", reg_r_a_val, 8'h14);
        check_eq("pre_arst_b", reg_r_b_val, 8'h1B);
        reset_n      = 1'b0;
        reg_w_addr   = 4'd4;
        reg_w_val    = 8'h55;
        reg_w_enable = 1'b1;
        #1;
        check_eq("arst_a", reg_r_a_val, 8'h00);
        check_eq("arst_b", reg_r_b_val, 8'h00);
        tick();
        check_eq("arst_wr_ign", reg_r_a_val, 8'h00);
        reg_w_enable = 1'b0;
        #2;
        reset_n = 1'b1;   // release between edges

        // Same-address dual read with back-to-back overwrites of r5.
        reg_r_a_addr = 4'd5;
        reg_r_b_addr = 4'd5;
        reg_w_addr   = 4'd5;
        reg_w_val    = 8'h33;
        reg_w_enable = 1'b1;
        #1;
        check_eq("r5_pre_a", reg_r_a_val, 8'h00);
        tick();
        check_eq("r5_first_a", reg_r_a_val, 8'h33);
        check_eq("r5_first_b", reg_r_b_val, 8'h33);
        reg_w_val = 8'hC4;
        tick();
        reg_w_enable = 1'b0;
        check_eq("r5_second_a", reg_r_a_val, 8'hC4);
        check_eq("r5_second_b", reg_r_b_val, 8'hC4);

        // Neighbouring registers hold their values.
        reg_r_a_addr = 4'd4;
        reg_r_b_addr = 4'd6;
        #1;
        check_eq("hold_r4", reg_r_a_val, 8'h00);
        check_eq("hold_r6", reg_r_b_val, 8'h00);

        // With the write enable low, r5 does not change.
        reg_r_a_addr = 4'd5;
        reg_w_val    = 8'h77;
        tick();
        check_eq("r5_no_wr", reg_r_a_val, 8'hC4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
